// File: rtl/eeprom_access_ctrl_if.sv
// Byte-level bus between the I2C bit/byte engine plus EEPROM array (master side)
// and eeprom_access_ctrl (slave side).
//   start_det/stop_det : 1-cycle bus condition pulses
//   rx_valid/rx_data   : received byte; ack_valid/ack : ACK decision one cycle later
//   tx_req             : master clocks out a read byte; tx_valid/tx_data : read byte
//   mem_*              : EEPROM array port (mem_rdata valid 1 cycle after mem_re)
//   busy               : controller is committing or in write-cycle time
//   wp                 : write protect, present only when WRITE_PROTECT_EN is defined
interface eeprom_access_ctrl_if;
  logic       start_det;
  logic       stop_det;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       ack_valid;
  logic       ack;
  logic       tx_req;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       busy;
`ifdef WRITE_PROTECT_EN
  logic       wp;
`endif

  modport master (
`ifdef WRITE_PROTECT_EN
    output wp,
`endif
    output start_det, stop_det, rx_valid, rx_data, tx_req, mem_rdata,
    input  ack_valid, ack, tx_valid, tx_data, mem_addr, mem_wdata, mem_we, mem_re, busy
  );

  modport slave (
`ifdef WRITE_PROTECT_EN
    input  wp,
`endif
    input  start_det, stop_det, rx_valid, rx_data, tx_req, mem_rdata,
    output ack_valid, ack, tx_valid, tx_data, mem_addr, mem_wdata, mem_we, mem_re, busy
  );
endinterface

// File: rtl/eeprom_access_ctrl.sv
// eeprom_access_ctrl: byte-level controller of an I2C EEPROM slave model.
// Decodes device / word-address bytes, owns the address pointer
// ({page, in-page count}), buffers a page write, commits it to the array
// after STOP and then models the write-cycle busy time (device NACKs).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : eeprom_access_ctrl_if.slave (byte engine + array signals)
// Optional build macro: WRITE_PROTECT_EN adds bus.wp; data bytes arriving
// while wp=1 are NACKed and dropped.
module eeprom_access_ctrl #(
  parameter logic [6:0]  DEV_ADDR  = 7'h50,
  parameter int unsigned PAGE_BITS = 3,
  parameter int unsigned WR_CYCLES = 1000
) (
  input logic                 clk,
  input logic                 rst_n,
  eeprom_access_ctrl_if.slave bus
);

  localparam int unsigned SLOTS = 1 << PAGE_BITS;
  localparam int unsigned WCW   = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEV,
    S_WADDR,
    S_WDATA,
    S_RDATA,
    S_COMMIT,
    S_WRITE_CYCLE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [7:0]           addr_ptr;
  logic [7:0]           page_buf [SLOTS];
  logic [SLOTS-1:0]     slot_valid;
  logic [PAGE_BITS-1:0] commit_idx;
  logic [WCW-1:0]       wr_cnt;
  logic                 ack_valid_q;
  logic                 ack_q;
  logic                 tx_valid_q;

  logic                 wp_block;
  logic                 dev_match;
  logic                 ctrl_evt;
  logic                 addr_load;
  logic                 wr_accept;
  logic                 commit_last;
  logic                 ack_nxt;
  logic                 mem_we_c;
  logic                 mem_re_c;
  logic [7:0]           mem_addr_c;
  logic [7:0]           mem_wdata_c;

`ifdef WRITE_PROTECT_EN
  assign wp_block = bus.wp;
`else
  assign wp_block = 1'b0;
`endif

  assign dev_match   = (bus.rx_data[7:1] == DEV_ADDR);
  assign ctrl_evt    = bus.start_det | bus.stop_det;
  // Bus conditions take priority over a byte arriving in the same cycle.
  assign addr_load   = (state == S_WADDR) && bus.rx_valid && !ctrl_evt;
  assign wr_accept   = (state == S_WDATA) && bus.rx_valid && !ctrl_evt && !wp_block;
  assign commit_last = (commit_idx == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ack_nxt     = 1'b0;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state)
      S_IDLE: begin
        if (bus.stop_det)       state_nxt = S_IDLE;
        else if (bus.start_det) state_nxt = S_DEV;
      end
      S_DEV: begin
        ack_nxt = dev_match;
        if (bus.stop_det)       state_nxt = S_IDLE;
        else if (bus.start_det) state_nxt = S_DEV;
        else if (bus.rx_valid) begin
          if (!dev_match)         state_nxt = S_IDLE;
          else if (bus.rx_data[0]) state_nxt = S_RDATA;
          else                     state_nxt = S_WADDR;
        end
      end
      S_WADDR: begin
        ack_nxt = 1'b1;
        if (bus.stop_det)       state_nxt = S_IDLE;
        else if (bus.start_det) state_nxt = S_DEV;
        else if (bus.rx_valid)  state_nxt = S_WDATA;
      end
      S_WDATA: begin
        ack_nxt = !wp_block;
        if (bus.stop_det)       state_nxt = (|slot_valid) ? S_COMMIT : S_IDLE;
        else if (bus.start_det) state_nxt = S_DEV;
      end
      S_RDATA: begin
        if (bus.stop_det)       state_nxt = S_IDLE;
        else if (bus.start_det) state_nxt = S_DEV;
        else if (bus.tx_req) begin
          mem_re_c   = 1'b1;
          mem_addr_c = addr_ptr;
        end
      end
      S_COMMIT: begin
        // Every slot costs one cycle; only valid slots strobe the array.
        if (slot_valid[commit_idx]) begin
          mem_we_c    = 1'b1;
          mem_addr_c  = {addr_ptr[7:PAGE_BITS], commit_idx};
          mem_wdata_c = page_buf[commit_idx];
        end
        if (commit_last) state_nxt = S_WRITE_CYCLE;
      end
      S_WRITE_CYCLE: begin
        // START/device bytes here are NACKed (ack_nxt stays 0): ACK polling.
        if (wr_cnt == WCW'(WR_CYCLES - 1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_ptr    <= '0;
      slot_valid  <= '0;
      commit_idx  <= '0;
      wr_cnt      <= '0;
      ack_valid_q <= 1'b0;
      ack_q       <= 1'b0;
      tx_valid_q  <= 1'b0;
    end else begin
      ack_valid_q <= bus.rx_valid && (state != S_RDATA);
      ack_q       <= bus.rx_valid && (state != S_RDATA) && ack_nxt;
      tx_valid_q  <= mem_re_c;

      if (addr_load)
        addr_ptr <= bus.rx_data;
      else if (wr_accept)
        // In-page counter wraps; page bits are untouched.
        addr_ptr[PAGE_BITS-1:0] <= addr_ptr[PAGE_BITS-1:0] + PAGE_BITS'(1);
      else if (mem_re_c)
        addr_ptr <= addr_ptr + 8'd1;

      if (wr_accept)
        slot_valid[addr_ptr[PAGE_BITS-1:0]] <= 1'b1;
      else if ((state == S_WDATA) && bus.start_det && !bus.stop_det)
        slot_valid <= '0;
      else if ((state == S_COMMIT) && commit_last)
        slot_valid <= '0;

      commit_idx <= (state == S_COMMIT) ? commit_idx + PAGE_BITS'(1) : '0;
      wr_cnt     <= (state == S_WRITE_CYCLE) ? wr_cnt + WCW'(1) : '0;
    end
  end

  // Data storage only; validity is tracked by slot_valid.
  always_ff @(posedge clk) begin
    if (wr_accept) page_buf[addr_ptr[PAGE_BITS-1:0]] <= bus.rx_data;
  end

  assign bus.ack_valid = ack_valid_q;
  assign bus.ack       = ack_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_valid_q ? bus.mem_rdata : '0;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_re    = mem_re_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.busy      = (state == S_COMMIT) || (state == S_WRITE_CYCLE);

endmodule

// File: tb/tb_eeprom_access_ctrl.sv
// Testbench for eeprom_access_ctrl: directed scenarios plus randomized page
// writes and sequential reads, checked against a byte-array reference model.
module tb_eeprom_access_ctrl;
  localparam int WR   = 40;
  localparam int PAGE = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eeprom_access_ctrl_if bus();

  eeprom_access_ctrl #(.DEV_ADDR(7'h50), .PAGE_BITS(3), .WR_CYCLES(WR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]  arr [256];
  logic        arr_init_done = 1'b0;
  logic [7:0]  model_mem [256];
  logic [15:0] we_log [$];
  logic [15:0] exp_log [$];
  logic [7:0]  wdata_q [$];
  logic [7:0]  model_ptr;
  logic [7:0]  saved [8];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          nb;

  // EEPROM array behaviour and write logging.
  always @(posedge clk) begin
    if (!arr_init_done) begin
      for (int i = 0; i < 256; i++) arr[i] <= 8'(i) ^ 8'hA5;
      arr_init_done <= 1'b1;
    end else begin
      if (bus.mem_re) bus.mem_rdata <= arr[bus.mem_addr];
      if (bus.mem_we) begin
        arr[bus.mem_addr] <= bus.mem_wdata;
        we_log.push_back({bus.mem_addr, bus.mem_wdata});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    bus.start_det = 1'b1;
    tick();
    bus.start_det = 1'b0;
  endtask

  task automatic send_stop();
    bus.stop_det = 1'b1;
    tick();
    bus.stop_det = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    check({tag, "_ackv"}, bus.ack_valid, 1);
    check({tag, "_ack"}, bus.ack, exp_ack);
    tick();
  endtask

  task automatic send_master_ack(input string tag);
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    check({tag, "_no_ackv"}, bus.ack_valid, 0);
  endtask

  task automatic read_byte(input string tag);
    bus.tx_req = 1'b1;
    #1;
    check({tag, "_mem_re"}, bus.mem_re, 1);
    check({tag, "_mem_addr"}, bus.mem_addr, model_ptr);
    @(posedge clk);
    #1;
    bus.tx_req = 1'b0;
    check({tag, "_tx_valid"}, bus.tx_valid, 1);
    check({tag, "_tx_data"}, bus.tx_data, model_mem[model_ptr]);
    model_ptr = model_ptr + 8'd1;
  endtask

  task automatic read_txn(input int n, input string tag);
    send_start();
    send_byte(8'hA1, 1'b1, {tag, "_dev"});
    for (int k = 0; k < n; k++) begin
      read_byte($sformatf("%s_rd%0d", tag, k));
      send_master_ack(tag);
    end
    send_stop();
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 10 * WR + 100) begin
      tick();
      n++;
    end
  endtask

  // Page-write rule: byte k lands in slot (start+k) mod PAGE of the start
  // page, last write wins; commit goes out in slot order.
  task automatic model_write(input logic [7:0] wa);
    logic [7:0] sb [PAGE];
    bit         sv [PAGE];
    logic [7:0] base;
    base = 8'((int'(wa) / PAGE) * PAGE);
    for (int s = 0; s < PAGE; s++) begin
      sv[s] = 1'b0;
      sb[s] = 8'h00;
    end
    for (int k = 0; k < wdata_q.size(); k++) begin
      int s;
      s = (int'(wa) + k) % PAGE;
      sb[s] = wdata_q[k];
      sv[s] = 1'b1;
    end
    exp_log.delete();
    for (int s = 0; s < PAGE; s++) begin
      if (sv[s]) begin
        exp_log.push_back({base | 8'(s), sb[s]});
        model_mem[base | 8'(s)] = sb[s];
      end
    end
    model_ptr = base | 8'((int'(wa) + wdata_q.size()) % PAGE);
  endtask

  task automatic write_begin(input logic [7:0] wa, input string tag);
    we_log.delete();
    send_start();
    send_byte(8'hA0, 1'b1, {tag, "_dev"});
    send_byte(wa, 1'b1, {tag, "_waddr"});
    for (int k = 0; k < wdata_q.size(); k++)
      send_byte(wdata_q[k], 1'b1, $sformatf("%s_d%0d", tag, k));
    send_stop();
    model_write(wa);
  endtask

  task automatic write_end(input string tag, input bit check_len);
    int n;
    wait_busy(n);
    if (check_len) check({tag, "_busy_len"}, n, WR + PAGE);
    check({tag, "_busy_low"}, bus.busy, 0);
    check({tag, "_nwrites"}, we_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++)
      if (i < we_log.size()) check($sformatf("%s_wr%0d", tag, i), we_log[i], exp_log[i]);
  endtask

  initial begin
    bus.start_det = 1'b0;
    bus.stop_det  = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.tx_req    = 1'b0;
`ifdef WRITE_PROTECT_EN
    bus.wp        = 1'b0;
`endif
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'hA5;
    model_ptr = 8'h00;
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_ack_valid", bus.ack_valid, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    rst_n = 1'b1;
    tick();

    // Single random write: 0x13 <= 0x5A
    wdata_q = '{8'h5A};
    write_begin(8'h13, "w1");
    write_end("w1", 1'b1);
    if (we_log.size() > 0) check("w1_const", we_log[0], 16'h135A);

    // Page wrap from 0x1E with four bytes
    wdata_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    write_begin(8'h1E, "wrap");
    write_end("wrap", 1'b1);
    if (we_log.size() > 0) check("wrap_first_const", we_log[0], 16'h1803);

    // Address-set only, then read across 0xFF -> 0x00
    wdata_q.delete();
    write_begin(8'hFE, "aset");
    tick();
    check("aset_no_busy", bus.busy, 0);
    check("aset_no_write", we_log.size(), 0);
    read_txn(3, "rwrap");
    check("rwrap_ptr", model_ptr, 8'h01);

    // Device address mismatch
    send_start();
    send_byte(8'hA4, 1'b0, "mismatch");
    send_byte(8'hA0, 1'b0, "mismatch_idle");
    send_stop();

    // STOP beats START in the same cycle
    send_start();
    send_byte(8'hA0, 1'b1, "sw_dev");
    bus.start_det = 1'b1;
    bus.stop_det  = 1'b1;
    tick();
    bus.start_det = 1'b0;
    bus.stop_det  = 1'b0;
    send_byte(8'hA0, 1'b0, "stop_wins");

    // ACK polling during write cycle
    wdata_q = '{8'h66};
    write_begin(8'h50, "poll");
    repeat (10) tick();
    check("poll_busy", bus.busy, 1);
    send_start();
    send_byte(8'hA0, 1'b0, "poll_nack");
    send_stop();
    check("poll_still_busy", bus.busy, 1);
    write_end("poll", 1'b0);
    send_start();
    send_byte(8'hA0, 1'b1, "poll_ack");
    send_stop();

    // Repeated-START abort: buffer discarded, pointer kept
    we_log.delete();
    send_start();
    send_byte(8'hA0, 1'b1, "rs_dev");
    send_byte(8'h40, 1'b1, "rs_waddr");
    send_byte(8'h77, 1'b1, "rs_data");
    send_start();
    send_byte(8'hA1, 1'b1, "rs_rdev");
    model_ptr = 8'h41;
    read_byte("rs_rd");
    send_stop();
    repeat (3) tick();
    check("rs_no_write", we_log.size(), 0);
    check("rs_no_busy", bus.busy, 0);

`ifdef WRITE_PROTECT_EN
    // Write protect: data byte NACKed, nothing committed
    we_log.delete();
    bus.wp = 1'b1;
    send_start();
    send_byte(8'hA0, 1'b1, "wp_dev");
    send_byte(8'h10, 1'b1, "wp_waddr");
    send_byte(8'h55, 1'b0, "wp_data");
    send_stop();
    tick();
    check("wp_no_busy", bus.busy, 0);
    check("wp_no_write", we_log.size(), 0);
    bus.wp = 1'b0;
    model_ptr = 8'h10;
`endif

    // Randomized page writes followed by sequential reads
    for (int it = 0; it < 6; it++) begin
      logic [7:0] wa;
      wa = 8'($urandom);
      nb = $urandom_range(12, 1);
      wdata_q.delete();
      for (int k = 0; k < nb; k++) wdata_q.push_back(8'($urandom));
      write_begin(wa, $sformatf("rw%0d", it));
      write_end($sformatf("rw%0d", it), 1'b1);
      read_txn($urandom_range(6, 1), $sformatf("rr%0d", it));
    end

    // Reset in the middle of a commit: later slots are lost
    for (int i = 0; i < 8; i++) saved[i] = model_mem[8'h80 + 8'(i)];
    wdata_q.delete();
    for (int k = 0; k < 8; k++) wdata_q.push_back(8'($urandom));
    write_begin(8'h80, "rstc");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstc_we_low", bus.mem_we, 0);
    check("rstc_busy_low", bus.busy, 0);
    tick();
    check("rstc_nwrites", we_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < we_log.size()) check($sformatf("rstc_wr%0d", i), we_log[i], exp_log[i]);
    for (int i = 3; i < 8; i++) model_mem[8'h80 + 8'(i)] = saved[i];
    rst_n = 1'b1;
    model_ptr = 8'h00;
    tick();
    read_txn(2, "post_rst");

    // Whole-array image against the model
    nb = 0;
    for (int i = 0; i < 256; i++) if (arr[i] !== model_mem[i]) nb++;
    check("mem_image_diffs", nb, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
